// File: rtl/quad_corner_tracker.sv
// Tracks the four extreme corners of the lit quad in a thresholded pixel stream.
// Optional macro CORNER_SMOOTH_EN averages accepted corners with the previous ones.
module quad_corner_tracker #(
    parameter int unsigned MIN_HITS   = 64,
    parameter int unsigned MISS_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [9:0]  in_x,
    input  logic [8:0]  in_y,
    input  logic        in_hit,
    input  logic        frame_done,
    output logic [9:0]  x1,
    output logic [8:0]  y1,
    output logic [9:0]  x2,
    output logic [8:0]  y2,
    output logic [9:0]  x3,
    output logic [8:0]  y3,
    output logic [9:0]  x4,
    output logic [8:0]  y4,
    output logic        corners_valid,
    output logic        corners_update,
    output logic [15:0] hit_count
);

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned KW = 11;
    localparam int unsigned CW = 16;
    localparam int unsigned MW = 4;

    localparam logic [XW-1:0] X_MAX = 10'd639;
    localparam logic [YW-1:0] Y_MAX = 9'd479;
    localparam logic [CW-1:0] CNT_SAT = 16'hFFFF;

    // Accumulator state for the frame in progress
    logic                 seen_q, seen_m;
    logic [CW-1:0]        cnt_q, cnt_m;
    logic [KW-1:0]        min_s_q, min_s_m, max_s_q, max_s_m;
    logic signed [KW-1:0] min_d_q, min_d_m, max_d_q, max_d_m;
    logic [XW-1:0]        c1x_q, c1x_m, c2x_q, c2x_m, c3x_q, c3x_m, c4x_q, c4x_m;
    logic [YW-1:0]        c1y_q, c1y_m, c2y_q, c2y_m, c3y_q, c3y_m, c4y_q, c4y_m;
    logic [MW-1:0]        miss_q, miss_n;

    logic [XW-1:0]        x1_n, x2_n, x3_n, x4_n;
    logic [YW-1:0]        y1_n, y2_n, y3_n, y4_n;
    logic                 valid_n, update_n;
    logic [CW-1:0]        hit_count_n;

    logic                 pix_hit_c;
    logic [KW-1:0]        pix_s_c;
    logic signed [KW-1:0] pix_d_c;

    assign pix_hit_c = in_valid && in_hit && (in_x <= X_MAX) && (in_y <= Y_MAX);
    assign pix_s_c   = KW'(in_x) + KW'(in_y);
    assign pix_d_c   = $signed(KW'(in_x)) - $signed(KW'(in_y));

`ifdef CORNER_SMOOTH_EN
    function automatic logic [XW-1:0] avg_x(input logic [XW-1:0] a, input logic [XW-1:0] b);
        logic [KW-1:0] t;
        t = KW'(a) + KW'(b) + KW'(1);
        return XW'(t >> 1);
    endfunction

    function automatic logic [YW-1:0] avg_y(input logic [YW-1:0] a, input logic [YW-1:0] b);
        logic [KW-1:0] t;
        t = KW'(a) + KW'(b) + KW'(1);
        return YW'(t >> 1);
    endfunction
`endif

    // Merge the current pixel into the accumulators (includes a pixel coincident with frame_done)
    always_comb begin
        seen_m  = seen_q;
        cnt_m   = cnt_q;
        min_s_m = min_s_q;
        max_s_m = max_s_q;
        min_d_m = min_d_q;
        max_d_m = max_d_q;
        c1x_m = c1x_q; c1y_m = c1y_q;
        c2x_m = c2x_q; c2y_m = c2y_q;
        c3x_m = c3x_q; c3y_m = c3y_q;
        c4x_m = c4x_q; c4y_m = c4y_q;
        if (pix_hit_c) begin
            seen_m = 1'b1;
            if (cnt_q != CNT_SAT) begin
                cnt_m = cnt_q + CW'(1);
            end
            if (!seen_q || (pix_s_c < min_s_q)) begin
                min_s_m = pix_s_c;
                c1x_m = in_x; c1y_m = in_y;
            end
            if (!seen_q || (pix_s_c > max_s_q)) begin
                max_s_m = pix_s_c;
                c3x_m = in_x; c3y_m = in_y;
            end
            if (!seen_q || (pix_d_c < min_d_q)) begin
                min_d_m = pix_d_c;
                c2x_m = in_x; c2y_m = in_y;
            end
            if (!seen_q || (pix_d_c > max_d_q)) begin
                max_d_m = pix_d_c;
                c4x_m = in_x; c4y_m = in_y;
            end
        end
    end

    // Frame close: accept or reject, and manage staleness
    always_comb begin
        x1_n = x1; y1_n = y1;
        x2_n = x2; y2_n = y2;
        x3_n = x3; y3_n = y3;
        x4_n = x4; y4_n = y4;
        valid_n     = corners_valid;
        update_n    = 1'b0;
        miss_n      = miss_q;
        hit_count_n = hit_count;
        if (frame_done) begin
            hit_count_n = cnt_m;
            if (32'(cnt_m) >= MIN_HITS) begin
                update_n = 1'b1;
                valid_n  = 1'b1;
                miss_n   = '0;
`ifdef CORNER_SMOOTH_EN
                if (corners_valid) begin
                    x1_n = avg_x(x1, c1x_m); y1_n = avg_y(y1, c1y_m);
                    x2_n = avg_x(x2, c2x_m); y2_n = avg_y(y2, c2y_m);
                    x3_n = avg_x(x3, c3x_m); y3_n = avg_y(y3, c3y_m);
                    x4_n = avg_x(x4, c4x_m); y4_n = avg_y(y4, c4y_m);
                end else begin
                    x1_n = c1x_m; y1_n = c1y_m;
                    x2_n = c2x_m; y2_n = c2y_m;
                    x3_n = c3x_m; y3_n = c3y_m;
                    x4_n = c4x_m; y4_n = c4y_m;
                end
`else
                x1_n = c1x_m; y1_n = c1y_m;
                x2_n = c2x_m; y2_n = c2y_m;
                x3_n = c3x_m; y3_n = c3y_m;
                x4_n = c4x_m; y4_n = c4y_m;
`endif
            end else begin
                if (32'(miss_q) < MISS_LIMIT) begin
                    miss_n = miss_q + MW'(1);
                end
                if (32'(miss_n) >= MISS_LIMIT) begin
                    valid_n = 1'b0;
                end
            end
        end
    end

    // Accumulator registers: cleared on frame close so the next cycle starts a fresh frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_q  <= 1'b0;
            cnt_q   <= '0;
            min_s_q <= '0;
            max_s_q <= '0;
            min_d_q <= '0;
            max_d_q <= '0;
            c1x_q <= '0; c1y_q <= '0;
            c2x_q <= '0; c2y_q <= '0;
            c3x_q <= '0; c3y_q <= '0;
            c4x_q <= '0; c4y_q <= '0;
        end else if (frame_done) begin
            seen_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            seen_q  <= seen_m;
            cnt_q   <= cnt_m;
            min_s_q <= min_s_m;
            max_s_q <= max_s_m;
            min_d_q <= min_d_m;
            max_d_q <= max_d_m;
            c1x_q <= c1x_m; c1y_q <= c1y_m;
            c2x_q <= c2x_m; c2y_q <= c2y_m;
            c3x_q <= c3x_m; c3y_q <= c3y_m;
            c4x_q <= c4x_m; c4y_q <= c4y_m;
        end
    end

    // Output registers; reset values describe the full-frame corners
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x1 <= 10'd0;   y1 <= 9'd0;
            x2 <= 10'd0;   y2 <= 9'd479;
            x3 <= 10'd639; y3 <= 9'd479;
            x4 <= 10'd639; y4 <= 9'd0;
            corners_valid  <= 1'b0;
            corners_update <= 1'b0;
            hit_count      <= '0;
            miss_q         <= '0;
        end else begin
            x1 <= x1_n; y1 <= y1_n;
            x2 <= x2_n; y2 <= y2_n;
            x3 <= x3_n; y3 <= y3_n;
            x4 <= x4_n; y4 <= y4_n;
            corners_valid  <= valid_n;
            corners_update <= update_n;
            hit_count      <= hit_count_n;
            miss_q         <= miss_n;
        end
    end

endmodule

// File: doc/quad_corner_tracker.md
Name: quad_corner_tracker

Overview:
- Upstream feeder of pixels_lost: consumes the thresholded camera pixel stream (640x480 raster, one hit flag per pixel).
- Extracts the four extreme corners of the lit quadrilateral each frame.
- Presents registered corner coordinates x1..y4 in the same order and widths pixels_lost expects.
- Holds the last good corners across bad frames and flags staleness.

Parameters:
- MIN_HITS, 64: minimum hit pixels in a frame for its corners to be accepted.
- MISS_LIMIT, 4: consecutive rejected frames before corners_valid drops (range 1..15).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_x/in_y/in_hit qualify this cycle
- in_x  in  10  pixel column 0..639
- in_y  in  9  pixel row 0..479
- in_hit  in  1  pixel belongs to the projected quad
- frame_done  in  1  one-cycle pulse; closes the current frame
- x1, y1  out  10, 9  top-left corner (min x+y)
- x2, y2  out  10, 9  bottom-left corner (max y-x)
- x3, y3  out  10, 9  bottom-right corner (max x+y)
- x4, y4  out  10, 9  top-right corner (max x-y)
- corners_valid  out  1  corners come from an accepted frame within MISS_LIMIT frames
- corners_update  out  1  one-cycle pulse when x1..y4 are rewritten
- hit_count  out  16  hit total of the last closed frame, saturating

Behaviour:
- Reset values (async, immediate): x1=0,y1=0; x2=0,y2=479; x3=639,y3=479; x4=639,y4=0; corners_valid=0; corners_update=0; hit_count=0. All accumulators, the miss counter and the "seen" flag clear.
- Per-frame accumulation on each cycle with in_valid && in_hit:
  - Keys: s = x+y, unsigned 11 bit; d = x-y, signed 11 bit.
  - Candidate 1 replaces the stored one if s < best_min_s; candidate 3 if s > best_max_s.
  - Candidate 4 replaces if d > best_max_d; candidate 2 if d < best_min_d.
  - Comparisons are strict, so ties keep the first pixel in raster order.
  - The first hit of a frame loads all four candidates unconditionally (seen flag).
  - Frame hit counter increments, saturating at 65535.
- in_valid with in_hit=0 changes only the position tracking (nothing stored).
- in_x>639 or in_y>479 with in_valid: pixel ignored entirely.
- frame_done (cycle N):
  - A pixel valid in the same cycle N belongs to the closing frame and is included.
  - Cycle N+1: hit_count <= frame count.
  - If count >= MIN_HITS: x1..y4 <= candidates, corners_update=1, corners_valid=1, miss counter=0.
  - Otherwise outputs hold, miss counter increments (saturating at MISS_LIMIT); corners_valid goes 0 when it reaches MISS_LIMIT.
  - Accumulators clear at N+1, so a pixel in cycle N+1 starts the new frame cleanly.
- frame_done on consecutive cycles: the second closes an empty frame (a miss).
- Reset asserted mid-frame: partial frame discarded; the next frame_done evaluates only post-reset pixels.
- No backpressure; one pixel per clock sustained.

Optional Feature:
- CORNER_SMOOTH_EN:
  - Defined: on an accepted frame, each output coordinate <= (old + new + 1) >> 1, computed at 11 bits and truncated back to 10/9 bits. Exception: the first accepted frame after reset or after corners_valid was 0 loads raw values.
  - Undefined: outputs load raw candidates. Latency is one cycle in both cases.

Test Plan:
- Filled square hits x,y in 80..160, MIN_HITS=64, frame_done -> one cycle later x1,y1=80,80; x2,y2=80,160; x3,y3=160,160; x4,y4=160,80; corners_update=1 for one cycle; corners_valid=1; hit_count=6561.
- Next frame with 10 hits -> corners hold the previous values, corners_update=0, hit_count=10, corners_valid stays 1.
- MISS_LIMIT=4, four consecutive empty frames -> corners_valid=0 after the 4th frame_done+1; corners still 80/160; a following good frame restores valid=1.
- Tie case: hits only on row 100, x 200..300 -> x1,y1=200,100 (first in raster); x3,y3=300,100; x2,y2=200,100; x4,y4=300,100.
- Reset pulsed mid-frame after 50 square hits, then 20 hits, then frame_done -> rejected (hit_count=20), outputs equal the full-frame reset values, valid=0.
- CORNER_SMOOTH_EN, accepted square 80..160 then square 100..180 -> second update gives x1,y1=90,90 and x3,y3=170,170.
